mul_seq: RTL

- Parametrised iterative shift-add multiplier; successor to the fixed 32-bit `mul` block.
- Adds a start/busy/done handshake and operand latching.
- Signedness is selectable per operand, so signed, unsigned and mixed products (mulh/mulhsu/mulhu style) are all supported.
- Sits in the execute stage as the multi-cycle multiply unit; the stall logic watches `busy`/`done`.

---
 rtl/mul_seq_if.sv | 24 ++
 rtl/mul_seq.sv | 106 ++++++++++
 2 files changed

// File: rtl/mul_seq_if.sv
// Handshake and operand/result bundle for the mul_seq iterative multiplier.
// The master requests a multiply; the slave (mul_seq) reports busy/done/y.
interface mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   a_signed;
    logic                   b_signed;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     y;

    modport master (
        output start, a, b, a_signed, b_signed,
        input  busy, done, y
    );

    modport slave (
        input  start, a, b, a_signed, b_signed,
        output busy, done, y
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier with per-operand signedness and start/busy/done handshake.
// Optional macro MUL_SEQ_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are zero.
module mul_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 neg_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   y_reg;

    logic                 accept;
    logic                 run_last;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_sum;

    // Magnitudes are formed on the raw inputs so only |a|, |b| and the result sign are latched.
    assign mag_a   = (bus.a_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b   = (bus.b_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign acc_sum = acc_reg + ({2*WIDTH{mplier_reg[0]}} & mcand_reg);

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign run_last = (mplier_reg[WIDTH-1:1] == '0) || (cnt_reg == LAST_CNT);
`else
    assign run_last = (cnt_reg == LAST_CNT);
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            y_reg      <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
            if (accept) begin
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
                mplier_reg <= mag_b;
                cnt_reg    <= '0;
                neg_reg    <= (bus.a_signed & bus.a[WIDTH-1]) ^ (bus.b_signed & bus.b[WIDTH-1]);
            end else if (state_reg == RUN) begin
                acc_reg    <= acc_sum;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + 1'b1;
                // Negating a zero accumulator yields zero, so no negative zero escapes.
                if (run_last) begin
                    y_reg <= neg_reg ? -acc_sum : acc_sum;
                end
            end
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.y    = y_reg;
endmodule
